// File: rtl/sa_pkg.sv
// Shared constants and state type for the 3x3 systolic-array operand feeder.
package sa_pkg;

    localparam int DW_DEF = 8;
    localparam int N      = 3;

    function automatic int prod_w(input int dw);
        return 2 * dw + 1;
    endfunction

    localparam int PW_DEF = prod_w(DW_DEF);

    localparam int               T_W      = 4;
    localparam logic [T_W-1:0]   FINISH_T = 4'd7;
    localparam logic [T_W-1:0]   T_LAST   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sa_skew.sv
// Diagonal skew: row i of A and column j of B are delayed by i and j cycles
// respectively so matching operands meet at PE(i,j).
module sa_skew
    import sa_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                  run_i,
    input  logic [T_W-1:0]        t_i,
    input  logic [N*N*DW-1:0]     a_i,
    input  logic [N*N*DW-1:0]     b_i,
    output logic [N*DW-1:0]       x_o,
    output logic [N*DW-1:0]       y_o
);

    always_comb begin
        x_o = '0;
        y_o = '0;
        if (run_i) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(t_i) == i + k) begin
                        x_o[i*DW +: DW] = a_i[(N*i + k)*DW +: DW];
                    end
                end
            end
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(t_i) == k + j) begin
                        y_o[j*DW +: DW] = b_i[(N*k + j)*DW +: DW];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sa_feeder.sv
// Operand feeder / result collector for a 3x3 systolic array.
// Optional RUN timeout with sticky err: define SA_FEEDER_TIMEOUT_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for an operand pair, array streams held at zero
// ST_RUN  | sa_start high, skewed streams driven, waiting for sa_finish
// ST_DONE | c_flat holds the result, out_valid high until out_ready
module sa_feeder
    import sa_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [9*DW-1:0]             a_flat,
    input  logic [9*DW-1:0]             b_flat,
    output logic                        sa_start,
    output logic signed [DW-1:0]        sa_x1,
    output logic signed [DW-1:0]        sa_x2,
    output logic signed [DW-1:0]        sa_x3,
    output logic signed [DW-1:0]        sa_y1,
    output logic signed [DW-1:0]        sa_y2,
    output logic signed [DW-1:0]        sa_y3,
    input  logic                        sa_finish,
    input  logic signed [2*DW:0]        sa_p11,
    input  logic signed [2*DW:0]        sa_p12,
    input  logic signed [2*DW:0]        sa_p13,
    input  logic signed [2*DW:0]        sa_p21,
    input  logic signed [2*DW:0]        sa_p22,
    input  logic signed [2*DW:0]        sa_p23,
    input  logic signed [2*DW:0]        sa_p31,
    input  logic signed [2*DW:0]        sa_p32,
    input  logic signed [2*DW:0]        sa_p33,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [9*(2*DW+1)-1:0]       c_flat,
    output logic                        busy,
    output logic                        err
);

    localparam int PW = prod_w(DW);

    state_t                  state_q, state_d;
    logic [T_W-1:0]          t_q, t_d;
    logic [N*N*DW-1:0]       a_q, a_d;
    logic [N*N*DW-1:0]       b_q, b_d;
    logic [N*N*PW-1:0]       c_q, c_d;
    logic [N*N*PW-1:0]       p_flat;
    logic [N*DW-1:0]         x_s, y_s;

`ifdef SA_FEEDER_TIMEOUT_EN
    logic                    err_q, err_d;
`endif

    // Products pass straight through; row-major with p11 in the low slot.
    assign p_flat = {sa_p33, sa_p32, sa_p31,
                     sa_p23, sa_p22, sa_p21,
                     sa_p13, sa_p12, sa_p11};

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
`ifdef SA_FEEDER_TIMEOUT_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a_flat;
                    b_d     = b_flat;
                    t_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sa_finish) begin
                    c_d     = p_flat;
                    state_d = ST_DONE;
                end
`ifdef SA_FEEDER_TIMEOUT_EN
                else if (t_q == T_LAST) begin
                    err_d   = 1'b1;
                    t_d     = '0;
                    state_d = ST_IDLE;
                end
`endif
                else if (t_q != T_LAST) begin
                    t_d = t_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

`ifdef SA_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    sa_skew #(
        .DW (DW)
    ) u_skew (
        .run_i (state_q == ST_RUN),
        .t_i   (t_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .x_o   (x_s),
        .y_o   (y_s)
    );

    assign sa_x1 = x_s[0*DW +: DW];
    assign sa_x2 = x_s[1*DW +: DW];
    assign sa_x3 = x_s[2*DW +: DW];
    assign sa_y1 = y_s[0*DW +: DW];
    assign sa_y2 = y_s[1*DW +: DW];
    assign sa_y3 = y_s[2*DW +: DW];

    assign in_ready  = (state_q == ST_IDLE);
    assign sa_start  = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign c_flat    = c_q;

endmodule

// File: doc/sa_feeder.md
SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 The block SHALL have parameter DW, default 8, the signed operand width matching the 3x3 systolic array.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a_flat/b_flat hold a new operand pair.
REQ-005 The block SHALL have port in_ready, output, 1 bit: an operand pair is accepted when in_valid and in_ready are both 1.
REQ-006 The block SHALL have ports a_flat and b_flat, input, 9*DW bits each: element [i][j] (i, j = 0..2) of A or B, row-major, at bits [(3*i+j)*DW +: DW], signed.
REQ-007 The block SHALL have port sa_start, output, 1 bit: the array start.
REQ-008 The block SHALL have ports sa_x1..sa_x3 and sa_y1..sa_y3, output, DW bits each, signed: skewed row and column streams to the array.
REQ-009 The block SHALL have port sa_finish, input, 1 bit: array result strobe.
REQ-010 The block SHALL have ports sa_p11..sa_p33, input, 2*DW+1 bits each, signed: array products, valid only while sa_finish is 1.
REQ-011 The block SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: result handshake.
REQ-012 The block SHALL have port c_flat, output, 9*(2*DW+1) bits: C[i][j] at [(3*i+j)*(2*DW+1) +: 2*DW+1], row-major.
REQ-013 The block SHALL have port busy, output, 1 bit, and port err, output, 1 bit (sticky timeout flag).

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 In IDLE: in_ready=1, sa_start=0, all sa_x*/sa_y*=0; on accept, latch A and B, clear cycle counter t, and go to RUN next cycle.
REQ-016 In RUN: sa_start=1; t increments by 1 per cycle starting at 0.
REQ-017 In RUN, the block SHALL drive sa_x(i+1) = A[i][t-i] when 0 <= t-i <= 2, otherwise 0.
REQ-018 In RUN, the block SHALL drive sa_y(j+1) = B[t-j][j] when 0 <= t-j <= 2, otherwise 0.
REQ-019 In RUN, on a cycle with sa_finish=1, the block SHALL register all nine sa_p into c_flat and go to DONE next cycle (expected at t=7).
REQ-020 In DONE: sa_start=0, streams=0, out_valid=1, c_flat stable; on out_ready=1 go to IDLE next cycle; in_ready=0.
REQ-021 sa_start SHALL deassert for at least one cycle between operations (guaranteed by DONE).
REQ-022 sa_finish outside RUN SHALL be ignored.
REQ-023 busy SHALL be 1 in RUN and DONE.
REQ-024 The block SHALL perform no arithmetic on products; widths SHALL pass through unchanged.

Reset
REQ-025 On rst=1, immediately and regardless of state (including mid-RUN): state=IDLE, t=0, sa_start=0, streams=0, c_flat=0, out_valid=0, busy=0, err=0; latched A/B SHALL be cleared to 0.

Configuration
REQ-026 The block SHALL support macro SA_FEEDER_TIMEOUT_EN.
REQ-027 With SA_FEEDER_TIMEOUT_EN defined: if t reaches 15 in RUN without sa_finish, the block SHALL set err=1 (sticky until rst), leave c_flat unchanged, and go to IDLE with no out_valid pulse.
REQ-028 Without SA_FEEDER_TIMEOUT_EN: RUN SHALL wait indefinitely for sa_finish (t saturates at 15), and err SHALL be tied 0.

Structure
REQ-029 A shared package sa_pkg SHALL hold DW default, array dimension N=3, product width 2*DW+1, the state enum, and the finish-cycle constant 7.
REQ-030 Skew generation SHALL be one sub-module, sa_skew, that maps the latched matrices and t to the six streams; the FSM and result capture remain in sa_feeder.

Verification
REQ-031 Identity A, B = [[1,2,3],[4,5,6],[7,8,9]], paired with the array: c_flat = B; out_valid rises 9 cycles after accept.
REQ-032 All A=127, all B=127: every C = 48387; all A=-128, all B=-128: every C = 49152; no overflow.
REQ-033 Stream check at t=2: sa_x1=A[0][2], sa_x2=A[1][1], sa_x3=A[2][0], sa_y1=B[2][0], sa_y2=B[1][1], sa_y3=B[0][2].
REQ-034 out_ready held 0 for 10 cycles in DONE: c_flat and out_valid stay constant and in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-035 rst asserted at t=4 in RUN: all outputs 0 immediately; the next accept then yields a correct result.
REQ-036 With SA_FEEDER_TIMEOUT_EN and sa_finish tied 0: err=1 at t=15, return to IDLE, out_valid never asserts.
